// File: rtl/ones_comp_mul_unit_pkg.sv
// Shared encodings for the ones'-complement multiply/add unit:
// FSM states, result-sign flags (priznak) and operation codes.
package ones_comp_mul_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_ADD  = 3'd2,
        ST_SIGN = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] PRIZ_ZERO = 2'b00;
    localparam logic [1:0] PRIZ_POS  = 2'b01;
    localparam logic [1:0] PRIZ_NEG  = 2'b10;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_ADD = 1'b1;

    function automatic logic [1:0] priznak_of(input logic is_zero, input logic msb);
        if (is_zero) begin
            return PRIZ_ZERO;
        end
        return msb ? PRIZ_NEG : PRIZ_POS;
    endfunction

endpackage

// File: rtl/ones_comp_mul_unit_adder.sv
// W-bit ones'-complement adder: the carry out of the MSB is folded back
// into bit 0 (end-around carry).
module ones_comp_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);

    logic [W:0] raw_sum;

    assign raw_sum = {1'b0, a_i} + {1'b0, b_i};
    assign sum_o   = raw_sum[W-1:0] + {{(W-1){1'b0}}, raw_sum[W]};

endmodule

// File: rtl/ones_comp_mul_unit.sv
// Ones'-complement multiply (shift-and-add over magnitudes) and add unit
// with sign/zero flags; one operation at a time under a small FSM.
module ones_comp_mul_unit
    import ones_comp_mul_unit_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           op,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           done,
    output logic [2*N-1:0] rr,
    output logic [1:0]     priznak,
    output logic [2:0]     dbg_state_o
);

    localparam int W  = 2 * N;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 2);

    // Handshake: an operation is accepted on the rising edge where start=1
    // and ready=1 (ready is high only in IDLE); start is ignored otherwise.
    // done pulses for exactly one cycle when rr/priznak carry the new result.

    state_t         state_q, state_d;
    logic           op_q, op_d;
    logic           sign_a_q, sign_a_d;
    logic           sign_b_q, sign_b_d;
    logic [N-2:0]   mag_a_q, mag_a_d;
    logic [N-2:0]   mag_b_q, mag_b_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   rr_q, rr_d;
    logic [1:0]     priz_q, priz_d;

    logic [W-1:0]   add_x, add_y, add_sum;
    logic [W-1:0]   ext_a, ext_b;
    logic [W-1:0]   mcand_shifted;
    logic [N-2:0]   mplier_shifted;
    logic [W-1:0]   mul_res, raw_res, norm_res;

    // Rebuild the original operands from sign+magnitude and sign-extend.
    assign ext_a = {{(N+1){sign_a_q}}, (sign_a_q ? ~mag_a_q : mag_a_q)};
    assign ext_b = {{(N+1){sign_b_q}}, (sign_b_q ? ~mag_b_q : mag_b_q)};

    assign mcand_shifted  = {{(N+1){1'b0}}, mag_a_q} << cnt_q;
    assign mplier_shifted = mag_b_q >> cnt_q;

    // One adder serves both the accumulate step and the ADD operation;
    // magnitude products never carry out, so end-around carry is inert there.
    always_comb begin
        add_x = acc_q;
        add_y = mplier_shifted[0] ? mcand_shifted : '0;
        if (state_q == ST_ADD) begin
            add_x = ext_a;
            add_y = ext_b;
        end
    end

    ones_comp_adder #(
        .W (W)
    ) u_adder (
        .a_i   (add_x),
        .b_i   (add_y),
        .sum_o (add_sum)
    );

    assign mul_res  = (sign_a_q ^ sign_b_q) ? ~acc_q : acc_q;
    assign raw_res  = (op_q == OP_ADD) ? acc_q : mul_res;
    assign norm_res = (&raw_res) ? '0 : raw_res;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        priz_d   = priz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d     = op;
                    sign_a_d = a[N-1];
                    sign_b_d = b[N-1];
                    mag_a_d  = a[N-1] ? ~a[N-2:0] : a[N-2:0];
                    mag_b_d  = b[N-1] ? ~b[N-2:0] : b[N-2:0];
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = (op == OP_ADD) ? ST_ADD : ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = add_sum;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SIGN;
                end
            end
            ST_ADD: begin
                acc_d   = add_sum;
                state_d = ST_SIGN;
            end
            ST_SIGN: begin
                rr_d    = norm_res;
                priz_d  = priznak_of(norm_res == '0, norm_res[W-1]);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            rr_q     <= '0;
            priz_q   <= PRIZ_ZERO;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            priz_q   <= priz_d;
        end
    end

    assign ready       = (state_q == ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign rr          = rr_q;
    assign priznak     = priz_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ones_comp_mul_unit.sv
// Bench for ones_comp_mul_unit (N=4): integer reference model, scoreboard
// queue checked every cycle, directed cases, random operations, resets.
module tb_ones_comp_mul_unit;

    localparam int N = 4;
    localparam int W = 2 * N;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] rr;
    logic [1:0]   priznak;
    logic [2:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W+1:0] exp_q[$];
    logic [W-1:0] held_rr = '0;
    logic [1:0]   held_pz = 2'b00;

    ones_comp_mul_unit #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .ready       (ready),
        .done        (done),
        .rr          (rr),
        .priznak     (priznak),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // Returns {priznak, rr}: decode operands to integers, do the arithmetic,
    // re-encode in 2N-bit ones' complement (zero is always +0).
    function automatic logic [W+1:0] model(input logic o, input logic [N-1:0] x, input logic [N-1:0] y);
        int vx, vy, r;
        logic [W-1:0] enc;
        logic [1:0] pz;
        vx = x[N-1] ? int'(x) - ((1 << N) - 1) : int'(x);
        vy = y[N-1] ? int'(y) - ((1 << N) - 1) : int'(y);
        r  = o ? vx + vy : vx * vy;
        enc = (r >= 0) ? W'(r) : W'(((1 << W) - 1) + r);
        if (r == 0)     pz = 2'b00;
        else if (r > 0) pz = 2'b01;
        else            pz = 2'b10;
        return {pz, enc};
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- scoreboard compare process ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
                end else begin
                    logic [W+1:0] e;
                    e = exp_q.pop_front();
                    check("done_rr", 32'(rr), 32'(e[W-1:0]));
                    check("done_priznak", 32'(priznak), 32'(e[W+1:W]));
                    held_rr = e[W-1:0];
                    held_pz = e[W+1:W];
                end
            end else begin
                check("hold_rr", 32'(rr), 32'(held_rr));
                check("hold_priznak", 32'(priznak), 32'(held_pz));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Runs one operation; optional stray start with other operands mid-flight.
    task automatic run_op(input logic o, input logic [N-1:0] x, input logic [N-1:0] y, input bit glitch);
        int lat;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_start", 32'(ready), 32'd1);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        exp_q.push_back(model(o, x, y));
        @(posedge clk);
        #1;
        lat   = 1;
        start = 1'b0;
        a     = 4'($urandom_range(0, 15));
        b     = 4'($urandom_range(0, 15));
        op    = 1'($urandom_range(0, 1));
        check("ready_low_busy", 32'(ready), 32'd0);
        if (glitch) begin
            start = 1'b1;
            op    = ~o;
            a     = ~x;
            b     = 4'b0111;
            @(posedge clk);
            #1;
            lat++;
            start = 1'b0;
            check("ready_low_after_glitch", 32'(ready), 32'd0);
        end
        while (!done && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within 50 cycles");
        end else begin
            check("latency", 32'(lat), (o ? 32'd3 : 32'(N + 1)));
        end
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("ready_after_done", 32'(ready), 32'd1);
    endtask

    initial begin
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        rst_n = 1'b0;
        #1;
        check("reset_rr", 32'(rr), 32'd0);
        check("reset_priznak", 32'(priznak), 32'd0);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Pin the model itself against hand-computed values.
        check("model_mul_3_m2", 32'(model(1'b0, 4'b0011, 4'b1101)), 32'h2F9);
        check("model_mul_m7_m7", 32'(model(1'b0, 4'b1000, 4'b1000)), 32'h131);
        check("model_mul_m0_5", 32'(model(1'b0, 4'b1111, 4'b0101)), 32'h000);
        check("model_add_5_m5", 32'(model(1'b1, 4'b0101, 4'b1010)), 32'h000);
        check("model_add_7_3", 32'(model(1'b1, 4'b0111, 4'b0011)), 32'h10A);

        // Directed cases with literal DUT expectations.
        run_op(1'b0, 4'b0011, 4'b1101, 1'b0);
        check("lit_rr_f9", 32'(rr), 32'hF9);
        check("lit_pz_neg", 32'(priznak), 32'h2);
        run_op(1'b0, 4'b1000, 4'b1000, 1'b0);
        check("lit_rr_31", 32'(rr), 32'h31);
        check("lit_pz_pos", 32'(priznak), 32'h1);
        run_op(1'b0, 4'b1111, 4'b0101, 1'b0);
        check("lit_rr_negzero_mul", 32'(rr), 32'h00);
        check("lit_pz_zero_mul", 32'(priznak), 32'h0);
        run_op(1'b1, 4'b0101, 4'b1010, 1'b0);
        check("lit_rr_negzero_add", 32'(rr), 32'h00);
        check("lit_pz_zero_add", 32'(priznak), 32'h0);
        run_op(1'b1, 4'b0111, 4'b0011, 1'b0);
        check("lit_rr_0a", 32'(rr), 32'h0A);
        check("lit_pz_pos_add", 32'(priznak), 32'h1);
        run_op(1'b0, 4'b0111, 4'b0111, 1'b0);
        run_op(1'b1, 4'b1000, 4'b1000, 1'b0);
        run_op(1'b0, 4'b0000, 4'b1111, 1'b0);

        // Stray start during CALC must be ignored.
        run_op(1'b0, 4'b0011, 4'b1101, 1'b1);
        check("glitch_rr_f9", 32'(rr), 32'hF9);
        run_op(1'b1, 4'b0110, 4'b0001, 1'b1);

        // Reset in the middle of CALC: immediate clear, operation dropped.
        run_op(1'b0, 4'b0111, 4'b0110, 1'b0);
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a     = 4'b0101;
        b     = 4'b0111;
        exp_q.push_back(model(1'b0, 4'b0101, 4'b0111));
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        held_rr = '0;
        held_pz = 2'b00;
        #1;
        check("midreset_rr", 32'(rr), 32'd0);
        check("midreset_priznak", 32'(priznak), 32'd0);
        check("midreset_ready", 32'(ready), 32'd1);
        check("midreset_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        run_op(1'b0, 4'b1010, 4'b0110, 1'b0);

        // Random operations.
        for (int i = 0; i < 60; i++) begin
            run_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), bit'($urandom_range(0, 7) == 0));
        end
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
